// File: rtl/ps2_op_pkg.sv
// Shared constants for the PS/2 operation scheduler: op codes, scancodes,
// decoder state encoding and the make-code lookup tables.
package ps2_op_pkg;

    localparam int NUM_OPS = 12;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_UP         = 4'd1;
    localparam logic [3:0] OP_DOWN       = 4'd2;
    localparam logic [3:0] OP_LEFT       = 4'd3;
    localparam logic [3:0] OP_RIGHT      = 4'd4;
    localparam logic [3:0] OP_TOGGLE     = 4'd5;
    localparam logic [3:0] OP_RUN_PAUSE  = 4'd6;
    localparam logic [3:0] OP_STEP       = 4'd7;
    localparam logic [3:0] OP_CLEAR      = 4'd8;
    localparam logic [3:0] OP_RANDOM     = 4'd9;
    localparam logic [3:0] OP_SPEED_UP   = 4'd10;
    localparam logic [3:0] OP_SPEED_DOWN = 4'd11;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [7:0] SC_UP         = 8'h1D;
    localparam logic [7:0] SC_DOWN       = 8'h1B;
    localparam logic [7:0] SC_LEFT       = 8'h1C;
    localparam logic [7:0] SC_RIGHT      = 8'h23;
    localparam logic [7:0] SC_TOGGLE     = 8'h29;
    localparam logic [7:0] SC_RUN_PAUSE  = 8'h5A;
    localparam logic [7:0] SC_STEP       = 8'h31;
    localparam logic [7:0] SC_CLEAR      = 8'h21;
    localparam logic [7:0] SC_RANDOM     = 8'h2D;
    localparam logic [7:0] SC_SPEED_UP   = 8'h55;
    localparam logic [7:0] SC_SPEED_DOWN = 8'h4E;

    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    function automatic logic [3:0] map_plain(input logic [7:0] code);
        case (code)
            SC_UP:         return OP_UP;
            SC_DOWN:       return OP_DOWN;
            SC_LEFT:       return OP_LEFT;
            SC_RIGHT:      return OP_RIGHT;
            SC_TOGGLE:     return OP_TOGGLE;
            SC_RUN_PAUSE:  return OP_RUN_PAUSE;
            SC_STEP:       return OP_STEP;
            SC_CLEAR:      return OP_CLEAR;
            SC_RANDOM:     return OP_RANDOM;
            SC_SPEED_UP:   return OP_SPEED_UP;
            SC_SPEED_DOWN: return OP_SPEED_DOWN;
            default:       return OP_NOP;
        endcase
    endfunction

    function automatic logic [3:0] map_ext(input logic [7:0] code);
        case (code)
            SC_X_UP:    return OP_UP;
            SC_X_DOWN:  return OP_DOWN;
            SC_X_LEFT:  return OP_LEFT;
            SC_X_RIGHT: return OP_RIGHT;
            default:    return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Shallow synchronous FIFO whose head entry and valid flag are registered,
// so the consumer sees a stable op until it is popped.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] remain;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          push_en, pop_en;

    assign full_o  = (count_q == FULL_CNT);
    assign pop_en  = pop_i && valid_q;
    assign push_en = push_i && (!full_o || pop_en);
    assign head_o  = head_q;
    assign valid_o = valid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        remain   = count_q - CW'(pop_en);
        count_d  = remain + CW'(push_en);
        valid_d  = (count_d != '0);
        // An entry written this edge can only become head if nothing older survives.
        if (remain == '0) begin
            head_d = push_en ? din_i : '0;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/ps2_op_scheduler.sv
// Decodes PS/2 set-2 scancodes into game op codes and queues them for the engine.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of held keys.
module ps2_op_scheduler
    import ps2_op_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic [3:0] op,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       overflow,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    // Last count value before the abandon threshold is reached.
    localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT_CYC - 2);

    dec_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    plain_op, ext_op;
    logic          make_req, brk_req;
    logic [3:0]    make_op, brk_op;
    logic          make_ok;
    logic          push_req;
    logic          fifo_full;
    logic          pop_now;

    assign plain_op = map_plain(key_data);
    assign ext_op   = map_ext(key_data);

    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        make_req = 1'b0;
        make_op  = OP_NOP;
        brk_req  = 1'b0;
        brk_op   = OP_NOP;
        if (key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_data == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (key_data == SC_F0) begin
                        state_d = ST_BRK;
                    end else if (plain_op != OP_NOP) begin
                        make_req = 1'b1;
                        make_op  = plain_op;
                    end
                end
                ST_EXT: begin
                    if (key_data == SC_F0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (ext_op != OP_NOP) begin
                            make_req = 1'b1;
                            make_op  = ext_op;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    brk_req = (plain_op != OP_NOP);
                    brk_op  = plain_op;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    brk_req = (ext_op != OP_NOP);
                    brk_op  = ext_op;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TO_HIT) begin
                state_d = ST_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [NUM_OPS-1:0] held_q;

    // A held key keeps its bit set until its break code arrives.
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_held
        always_ff @(posedge clk) begin
            if (rst) begin
                held_q[gi] <= 1'b0;
            end else if (make_req && make_op == 4'(gi)) begin
                held_q[gi] <= 1'b1;
            end else if (brk_req && brk_op == 4'(gi)) begin
                held_q[gi] <= 1'b0;
            end
        end
    end

    assign make_ok = !held_q[make_op];
`else
    logic unused_brk;
    assign unused_brk = ^{brk_req, brk_op};
    assign make_ok    = 1'b1;
`endif

    assign push_req   = make_req && make_ok;
    assign pop_now    = op_valid && op_ready;
    assign overflow_d = overflow_q | (push_req && fifo_full && !pop_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (4)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .din_i   (make_op),
        .pop_i   (op_ready),
        .head_o  (op),
        .valid_o (op_valid),
        .full_o  (fifo_full)
    );

    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_op_scheduler.sv
// Scoreboard bench for ps2_op_scheduler: a byte-level reference model queues
// expected ops; a negedge monitor checks handshake, busy, overflow and op values.
module tb_ps2_op_scheduler;
    localparam int DEPTH = 4;
    localparam int TO    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       op_ready = 1'b0;
    logic [3:0] op;
    logic       op_valid;
    logic       overflow;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_pops  = 0;

    int exp_q[$];
    bit m_ovf;
    bit m_e0;
    bit m_f0;
    int m_gap;
    bit m_held[16];

    always #5 clk = ~clk;

    ps2_op_scheduler #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_data  (key_data),
        .key_valid (key_valid),
        .op        (op),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_plain(input logic [7:0] b);
        case (b)
            8'h1D: return 1;  8'h1B: return 2;  8'h1C: return 3;  8'h23: return 4;
            8'h29: return 5;  8'h5A: return 6;  8'h31: return 7;  8'h21: return 8;
            8'h2D: return 9;  8'h55: return 10; 8'h4E: return 11;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_ext(input logic [7:0] b);
        case (b)
            8'h75: return 1; 8'h72: return 2; 8'h6B: return 3; 8'h74: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void ref_make(input int o);
        if (o == 0) return;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (m_held[o]) return;
        m_held[o] = 1'b1;
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(o);
        else m_ovf = 1'b1;
    endfunction

    function automatic void ref_release(input int o);
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (o != 0) m_held[o] = 1'b0;
`else
        if (o < 0) m_ovf = 1'b1;
`endif
    endfunction

    function automatic void ref_byte(input logic [7:0] b);
        // A prefix left idle for TO-1 cycles is forgotten.
        if ((m_e0 || m_f0) && m_gap >= TO - 1) begin
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
        if (!m_e0 && !m_f0) begin
            if (b == 8'hE0) m_e0 = 1'b1;
            else if (b == 8'hF0) m_f0 = 1'b1;
            else ref_make(ref_plain(b));
        end else if (m_e0 && !m_f0) begin
            if (b == 8'hF0) m_f0 = 1'b1;
            else begin
                m_e0 = 1'b0;
                ref_make(ref_ext(b));
            end
        end else begin
            ref_release(m_e0 ? ref_ext(b) : ref_plain(b));
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_e0  = 1'b0;
            m_f0  = 1'b0;
            m_gap = 0;
            for (int i = 0; i < 16; i++) m_held[i] = 1'b0;
        end else begin
            chk("op_valid", int'(op_valid), int'(exp_q.size() != 0));
            chk("busy", int'(busy), int'((m_e0 || m_f0) && m_gap < TO - 1));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (exp_q.size() != 0 && op_ready) begin
                int e;
                e = exp_q.pop_front();
                n_pops++;
                chk("op_value", int'(op), e);
                $display("pop op=%0d expected=%0d t=%0t", op, e, $time);
            end
            if (key_valid) begin
                ref_byte(key_data);
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        key_data  = b;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        tick(gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    logic [7:0] pool [20];

    initial begin
        int p0;
        int g;
        int r;
        pool[0] = 8'h1D;  pool[1] = 8'h1B;  pool[2] = 8'h1C;  pool[3] = 8'h23;
        pool[4] = 8'h29;  pool[5] = 8'h5A;  pool[6] = 8'h31;  pool[7] = 8'h21;
        pool[8] = 8'h2D;  pool[9] = 8'h55;  pool[10] = 8'h4E; pool[11] = 8'h75;
        pool[12] = 8'h72; pool[13] = 8'h6B; pool[14] = 8'h74; pool[15] = 8'hE0;
        pool[16] = 8'hE0; pool[17] = 8'hF0; pool[18] = 8'hF0; pool[19] = 8'hE1;

        tick(3);
        rst = 1'b0;
        chk("reset_op", int'(op), 0);
        chk("reset_op_valid", int'(op_valid), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_busy", int'(busy), 0);

        // Single make, one-cycle latency, one-cycle valid with ready held high.
        op_ready = 1'b1;
        send(8'h1D, 0);
        chk("lat_valid", int'(op_valid), 1);
        chk("lat_op", int'(op), 1);
        tick(1);
        chk("lat_valid_drop", int'(op_valid), 0);

        // Extended make then extended break: one UP only.
        p0 = n_pops;
        send(8'hE0, 0);
        chk("busy_after_e0", int'(busy), 1);
        send(8'h75, 2);
        send(8'hE0, 0);
        send(8'hF0, 0);
        chk("busy_ext_brk", int'(busy), 1);
        send(8'h75, 0);
        chk("busy_done", int'(busy), 0);
        tick(3);
        chk("ext_pops", n_pops - p0, 1);

        // Simultaneous pop and push on a full queue.
        do_reset();
        op_ready = 1'b0;
        send(8'h1D, 0); send(8'h1B, 0); send(8'h1C, 0); send(8'h1D, 0);
        key_data  = 8'h23;
        key_valid = 1'b1;
        op_ready  = 1'b1;
        tick(1);
        key_valid = 1'b0;
        op_ready  = 1'b0;
        chk("full_pushpop_ovf", int'(overflow), 0);
        op_ready = 1'b1;
        tick(6);

        // Overflow: fifth op is dropped, first four drain in order.
        op_ready = 1'b0;
        send(8'h29, 0); send(8'h5A, 0); send(8'h31, 0); send(8'h21, 0); send(8'h2D, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head", int'(op), 5);
        op_ready = 1'b1;
        tick(6);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset with a non-empty queue.
        op_ready = 1'b0;
        send(8'h31, 0); send(8'h21, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_clears_valid", int'(op_valid), 0);
        chk("rst_clears_ovf", int'(overflow), 0);
        tick(1);

        // Typematic repeats around a break.
        op_ready = 1'b1;
        p0 = n_pops;
        send(8'h1D, 1); send(8'h1D, 1); send(8'h1D, 1);
        send(8'hF0, 1); send(8'h1D, 1); send(8'h1D, 1);
        tick(3);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typematic_pops", n_pops - p0, 2);
`else
        chk("typematic_pops", n_pops - p0, 4);
`endif

        // Timeout boundary: TO-2 idle cycles keep the prefix, TO-1 drop it.
        do_reset();
        op_ready = 1'b1;
        p0 = n_pops;
        send(8'hE0, TO - 2);
        send(8'h75, 3);
        chk("timeout_kept", n_pops - p0, 1);
        p0 = n_pops;
        send(8'hE0, TO - 1);
        chk("timeout_busy", int'(busy), 0);
        send(8'h72, 3);
        send(8'hE0, TO + 60);
        send(8'h72, 3);
        chk("timeout_dropped", n_pops - p0, 0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 23));
            op_ready = ($urandom_range(0, 2) != 0);
            if (r < 20) key_data = pool[r];
            else key_data = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 19));
            if (r == 0) g = TO - 2;
            else if (r == 1) g = TO - 1;
            else if (r == 2) g = TO + int'($urandom_range(0, 3));
            else if (r < 8) g = 0;
            else g = int'($urandom_range(1, 3));
            send(key_data, g);
        end
        op_ready = 1'b1;
        tick(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_op_scheduler.md
# ps2_op_scheduler

Sequences raw PS/2 set-2 scancode bytes from the keyboard receiver into the 4-bit user operation codes consumed by the Life Game controller. Decodes E0/F0 prefixes with a small state machine and maps make codes to operations. Queues operations in a shallow FIFO and delivers them over a valid/ready handshake, so the game engine drains keystrokes only at its own step boundaries.

## Interface
- DEPTH, 4: operation queue entries; power of two, ≥2.
- TIMEOUT_CYC, 100000: idle cycles after a prefix byte before the decoder abandons the partial sequence.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_data  in  8  received scancode byte.
- key_valid  in  1  single-cycle strobe; key_data valid this cycle.
- op  out  4  head-of-queue operation code.
- op_valid  out  1  op holds a pending operation.
- op_ready  in  1  consumer accepts op this cycle.
- overflow  out  1  sticky; an operation was dropped because the queue was full.
- busy  out  1  decoder is mid-sequence (state ≠ IDLE).

One clock; reset is synchronous and active-high.

## Operation
- Op codes: 0 NOP (never queued), 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 TOGGLE, 6 RUN_PAUSE, 7 STEP, 8 CLEAR, 9 RANDOM, 10 SPEED_UP, 11 SPEED_DOWN; 12–15 reserved.
- Plain make codes: 1D→UP, 1B→DOWN, 1C→LEFT, 23→RIGHT, 29→TOGGLE, 5A→RUN_PAUSE, 31→STEP, 21→CLEAR, 2D→RANDOM, 55→SPEED_UP, 4E→SPEED_DOWN.
- Extended make codes (after E0): 75→UP, 72→DOWN, 6B→LEFT, 74→RIGHT; all other extended codes are dropped.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT, F0→BRK, any other byte is looked up; a mapped code is pushed, an unmapped code is dropped; stay IDLE.
  - EXT: F0→EXT_BRK; other bytes are looked up in the extended table, pushed if mapped; →IDLE.
  - BRK / EXT_BRK: the byte is a break code, never pushed; →IDLE.
- E1 and unmapped bytes in IDLE are dropped with no state change.
- Timeout: in any non-IDLE state, a counter increments each cycle without key_valid. Reaching TIMEOUT_CYC−1 forces IDLE, and the partial sequence is discarded. The counter clears on every key_valid and in IDLE.
- Queue push is accepted when not full, or when full and a pop occurs in the same cycle. Otherwise the op is dropped and overflow is set. overflow clears only on rst.
- Pop occurs when op_valid && op_ready. Simultaneous push and pop on an empty queue is impossible (op_valid=0); on a non-empty queue, both complete.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset values: op=0, op_valid=0, overflow=0, busy=0, state IDLE, timer 0, queue empty, held mask 0.
- Latency: key_valid on the final byte of a mapped make at cycle t → entry written at edge t+1 → op_valid=1 from cycle t+1 (empty queue).
- op and op_valid are registered. op is stable while op_valid && !op_ready. The next entry is presented the cycle after a pop.
- busy rises the cycle after a prefix byte and falls the cycle after the completing byte or timeout.
- rst mid-sequence or with a non-empty queue discards everything; op_valid is low the following cycle.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined:
  - A 12-bit held mask is indexed by op code.
  - A make whose op bit is already set is dropped; otherwise it is pushed and the bit is set.
  - A break (plain or extended) of a mapped code clears that op's bit.
  - Holding a key yields exactly one op.
- Not defined: no held mask. Every make, including typematic repeats, is pushed, so holding an arrow key repeats cursor moves.

## Structure
- Shared package ps2_op_pkg:
  - op code localparams (OP_NOP…OP_SPEED_DOWN);
  - scancode constants (SC_E0, SC_F0, SC_E1, key codes);
  - FSM state encoding.
- Sub-module op_fifo: DEPTH×4 synchronous FIFO with push/pop, full/empty and registered head output. The scheduler instantiates it once.

## Test plan
- Byte 1D, op_ready=1 → op=1 with op_valid for exactly one cycle, at t+1.
- Bytes E0,75 then E0,F0,75 → exactly one op=1 is queued; busy is high between bytes; no op from the break.
- op_ready=0; push 5 ops (29,5A,31,21,2D) with DEPTH=4 → the first four are queued, the fifth is dropped, overflow=1. Draining returns 5,6,7,8 in order.
- Byte E0, then 100000 idle cycles, then 72 → timeout returns the FSM to IDLE; 72 decodes as plain (unmapped) and is dropped; no op.
- Queue full, op_ready=1, and byte 23 in the same cycle → pop and push both occur; RIGHT (4) appears last; overflow stays 0.
- Bytes 1D,1D,1D,F0,1D,1D:
  - with PS2_TYPEMATIC_FILTER_EN → ops 1,1;
  - without the macro → ops 1,1,1,1.
  - rst asserted mid-queue clears op_valid next cycle.
